// File: rtl/hilbert_analytic_fir.sv
// Real-to-analytic converter: re = input delayed to the FIR centre, im = Hilbert FIR on one shared MAC.
// Result valid NC+1 edges after accept; din_ready stays low until the result is taken.
module hilbert_analytic_fir #(
   parameter int  G_DWIDTH   = 24,
   parameter int  G_NUM_TAPS = 31,
   parameter int  G_CWIDTH   = 18,
   localparam int M          = (G_NUM_TAPS - 1) / 2,
   localparam int NC         = (M + 1) / 2,
   localparam int AW         = (NC > 1) ? $clog2(NC) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_enable,
   input  logic                       i_coef_wr_en,
   input  logic [AW-1:0]              i_coef_addr,
   input  logic signed [G_CWIDTH-1:0] i_coef_data,
   input  logic signed [G_DWIDTH-1:0] i_din,
   input  logic                       i_din_valid,
   output logic                       o_din_ready,
   output logic signed [G_DWIDTH-1:0] o_dout_re,
   output logic signed [G_DWIDTH-1:0] o_dout_im,
   output logic                       o_dout_valid,
   input  logic                       i_dout_ready
);
   localparam int DIFW = G_DWIDTH + 1;
   localparam int PRDW = DIFW + G_CWIDTH;
   localparam int ACCW = PRDW + AW + 1;
   localparam logic signed [ACCW-1:0]     C_RND = ACCW'(1) << (G_CWIDTH - 2);
   localparam logic signed [G_DWIDTH-1:0] C_MAX = {1'b0, {(G_DWIDTH-1){1'b1}}};
   localparam logic signed [G_DWIDTH-1:0] C_MIN = {1'b1, {(G_DWIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

   state_t                     r_state, w_state_nxt;
   logic signed [G_DWIDTH-1:0] r_dly [G_NUM_TAPS];
   logic signed [G_CWIDTH-1:0] r_coef [NC];
   logic signed [ACCW-1:0]     r_acc;
   logic [AW-1:0]              r_idx;
   logic                       r_din_rdy, r_dout_vld;
   logic signed [G_DWIDTH-1:0] r_dout_re, r_dout_im;

   logic                       w_accept, w_release, w_mac_last, w_coef_we;
   logic signed [G_DWIDTH-1:0] w_tap_new, w_tap_old;
   logic signed [G_CWIDTH-1:0] w_coef;
   logic signed [DIFW-1:0]     w_diff;
   logic signed [PRDW-1:0]     w_prod;
   logic signed [ACCW-1:0]     w_rnd, w_shf;
   logic [ACCW-G_DWIDTH:0]     w_hi;
   logic                       w_ovf;
   logic signed [G_DWIDTH-1:0] w_im_sat;

   assign w_accept   = (r_state == S_IDLE) && i_din_valid && r_din_rdy;
   assign w_release  = (r_state == S_OUT) && r_dout_vld && i_dout_ready;
   assign w_mac_last = (r_idx == AW'(NC - 1));
   assign w_coef_we  = i_coef_wr_en && (r_state != S_MAC) && (r_state != S_ROUND)
                       && ({1'b0, i_coef_addr} < (AW+1)'(NC));

   // Symmetric tap pair for offset k=2i+1 around the centre M.
   always_comb begin
      w_tap_new = '0;
      w_tap_old = '0;
      w_coef    = '0;
      for (int i = 0; i < NC; i++) begin
         if (r_idx == AW'(i)) begin
            w_tap_new = r_dly[M-1-2*i];
            w_tap_old = r_dly[M+1+2*i];
            w_coef    = r_coef[i];
         end
      end
   end

   assign w_diff = {w_tap_new[G_DWIDTH-1], w_tap_new} - {w_tap_old[G_DWIDTH-1], w_tap_old};
   assign w_prod = PRDW'(w_diff) * PRDW'(w_coef);

   // Round half up, drop the Q1 fraction, then clamp to the sample range.
   assign w_rnd    = r_acc + C_RND;
   assign w_shf    = w_rnd >>> (G_CWIDTH - 1);
   assign w_hi     = w_shf[ACCW-1:G_DWIDTH-1];
   assign w_ovf    = !((&w_hi) || !(|w_hi));
   assign w_im_sat = w_ovf ? (w_shf[ACCW-1] ? C_MIN : C_MAX) : w_shf[G_DWIDTH-1:0];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  w_state_nxt = S_IDLE;
         S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
         S_MAC:   if (w_mac_last) w_state_nxt = S_ROUND;
         S_ROUND: w_state_nxt = S_OUT;
         S_OUT:   if (w_release) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)     r_state <= S_INIT;
      else if (!i_enable) r_state <= S_INIT;
      else                r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int j = 0; j < G_NUM_TAPS; j++) r_dly[j] <= '0;
         for (int i = 0; i < NC; i++) r_coef[i] <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_din_rdy  <= 1'b0;
         r_dout_vld <= 1'b0;
         r_dout_re  <= '0;
         r_dout_im  <= '0;
      end else if (!i_enable) begin
         // Soft clear keeps the coefficient bank.
         for (int j = 0; j < G_NUM_TAPS; j++) r_dly[j] <= '0;
         r_acc      <= '0;
         r_idx      <= '0;
         r_din_rdy  <= 1'b0;
         r_dout_vld <= 1'b0;
         r_dout_re  <= '0;
         r_dout_im  <= '0;
      end else begin
         if (w_coef_we) r_coef[i_coef_addr] <= i_coef_data;
         case (r_state)
            S_INIT: r_din_rdy <= 1'b1;
            S_IDLE: begin
               if (w_accept) begin
                  for (int j = G_NUM_TAPS - 1; j > 0; j--) r_dly[j] <= r_dly[j-1];
                  r_dly[0]  <= i_din;
                  r_din_rdy <= 1'b0;
                  r_acc     <= '0;
                  r_idx     <= '0;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + ACCW'(w_prod);
               r_idx <= r_idx + AW'(1);
            end
            S_ROUND: begin
               r_dout_re  <= r_dly[M];
               r_dout_im  <= w_im_sat;
               r_dout_vld <= 1'b1;
            end
            S_OUT: begin
               if (w_release) begin
                  r_dout_vld <= 1'b0;
                  r_din_rdy  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_din_ready  = r_din_rdy;
   assign o_dout_valid = r_dout_vld;
   assign o_dout_re    = r_dout_re;
   assign o_dout_im    = r_dout_im;
endmodule

// File: tb/tb_hilbert_analytic_fir.sv
// Bench for hilbert_analytic_fir: random and directed stimulus against a sample-history model of the FIR.
module tb_hilbert_analytic_fir;
   localparam int DW = 24;
   localparam int N  = 31;
   localparam int CW = 18;
   localparam int M  = 15;
   localparam int NC = 8;
   localparam int AW = 3;

   logic                 i_clk = 1'b0;
   logic                 i_reset_n = 1'b0;
   logic                 i_enable = 1'b1;
   logic                 i_coef_wr_en = 1'b0;
   logic [AW-1:0]        i_coef_addr = '0;
   logic signed [CW-1:0] i_coef_data = '0;
   logic signed [DW-1:0] i_din = '0;
   logic                 i_din_valid = 1'b0;
   logic                 o_din_ready;
   logic signed [DW-1:0] o_dout_re, o_dout_im;
   logic                 o_dout_valid;
   logic                 i_dout_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rdy_mode = 1;
   bit prev_vld = 1'b0;

   logic signed [CW-1:0] mc [NC];
   logic signed [DW-1:0] hist[$];
   longint exp_re[$], exp_im[$], got_re[$], got_im[$];
   int acc_q[$], acc_log[$];

   hilbert_analytic_fir dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
      .i_coef_wr_en(i_coef_wr_en), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
      .i_din(i_din), .i_din_valid(i_din_valid), .o_din_ready(o_din_ready),
      .o_dout_re(o_dout_re), .o_dout_im(o_dout_im), .o_dout_valid(o_dout_valid),
      .i_dout_ready(i_dout_ready)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   always @(posedge i_clk) begin
      #2;
      case (rdy_mode)
         0:       i_dout_ready = 1'b0;
         1:       i_dout_ready = 1'b1;
         default: i_dout_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic chk(input string tag, input longint got, input longint want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   function automatic longint dget(input int j);
      if (j < hist.size()) return longint'(hist[j]);
      return 0;
   endfunction

   // im = sum c[i]*(x[n-(M-k)] - x[n-(M+k)]), rounded and clamped; re = x[n-M].
   function automatic void model(output longint re, output longint im);
      longint acc = 0;
      for (int i = 0; i < NC; i++)
         acc += longint'(mc[i]) * (dget(M - (2*i+1)) - dget(M + (2*i+1)));
      im = (acc + 65536) >>> 17;
      if (im > 8388607)  im = 8388607;
      if (im < -8388608) im = -8388608;
      re = dget(M);
   endfunction

   always @(negedge i_clk) begin
      longint mre, mim;
      if (i_reset_n && i_enable) begin
         chk("ready_valid_exclusive", o_din_ready & o_dout_valid, 0);
         if (i_din_valid && o_din_ready) begin
            hist.push_front(i_din);
            if (hist.size() > N) void'(hist.pop_back());
            model(mre, mim);
            exp_re.push_back(mre);
            exp_im.push_back(mim);
            acc_q.push_back(cyc + 1);
            acc_log.push_back(cyc + 1);
         end
         if (o_dout_valid && !prev_vld) begin
            chk("latency_pending", acc_q.size() > 0, 1);
            if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 9);
         end
         prev_vld = o_dout_valid;
         if (o_dout_valid && i_dout_ready) begin
            chk("out_expected", exp_im.size() > 0, 1);
            if (exp_im.size() > 0) begin
               chk("re", o_dout_re, exp_re.pop_front());
               chk("im", o_dout_im, exp_im.pop_front());
            end
            got_re.push_back(o_dout_re);
            got_im.push_back(o_dout_im);
         end
      end else begin
         prev_vld = 1'b0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic clear_model();
      hist.delete();
      exp_re.delete();
      exp_im.delete();
      acc_q.delete();
   endtask

   task automatic send(input logic signed [DW-1:0] x);
      bit ok = 1'b0;
      i_din       = x;
      i_din_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge i_clk);
         if (o_din_ready) ok = 1'b1;
      end
      @(posedge i_clk);
      #1;
      i_din_valid = 1'b0;
      if (!ok) chk("send_timeout", ok, 1);
   endtask

   task automatic wcoef(input int a, input logic signed [CW-1:0] v, input bit upd);
      i_coef_wr_en = 1'b1;
      i_coef_addr  = AW'(a);
      i_coef_data  = v;
      tick(1);
      i_coef_wr_en = 1'b0;
      if (upd) mc[a] = v;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_im.size() > 0 && t < 1000) begin
         tick(1);
         t++;
      end
      if (exp_im.size() > 0) chk("drain_timeout", exp_im.size(), 0);
      tick(2);
   endtask

   task automatic impulse_seq(input bit mac_wr);
      got_re.delete();
      got_im.delete();
      send(24'sd1000);
      if (mac_wr) wcoef(0, 18'sh20000, 1'b0);
      for (int j = 1; j < 20; j++) send('0);
      drain();
      chk("imp_count", got_im.size(), 20);
      for (int j = 0; j < 20 && j < got_im.size(); j++) begin
         chk($sformatf("imp_im%0d", j), got_im[j], (j == 14) ? 500 : ((j == 16) ? -500 : 0));
         chk($sformatf("imp_re%0d", j), got_re[j], (j == 15) ? 1000 : 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, want < 50000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [DW-1:0] x, hold_re, hold_im;
      bit stable, rdy_bad;
      int t;
      for (int i = 0; i < NC; i++) mc[i] = '0;

      // Reset state and release
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_din_ready", o_din_ready, 0);
      chk("rst_dout_valid", o_dout_valid, 0);
      chk("rst_dout_re", o_dout_re, 0);
      chk("rst_dout_im", o_dout_im, 0);
      i_reset_n = 1'b1;
      tick(2);
      chk("rst_ready_2nd_edge", o_din_ready, 1);

      // Impulse through c[0] = 0.5
      wcoef(0, 18'sh10000, 1'b1);
      for (int i = 1; i < NC; i++) wcoef(i, '0, 1'b1);
      impulse_seq(1'b0);

      // Soft clear mid-MAC, then identical impulse with an ignored MAC-time write
      for (int s = 0; s < 3; s++) send(DW'($urandom));
      tick(1);
      i_enable = 1'b0;
      clear_model();
      tick(2);
      chk("clr_din_ready", o_din_ready, 0);
      chk("clr_dout_valid", o_dout_valid, 0);
      chk("clr_dout_re", o_dout_re, 0);
      chk("clr_dout_im", o_dout_im, 0);
      i_enable = 1'b1;
      impulse_seq(1'b1);

      // Saturation
      for (int i = 0; i < NC; i++) wcoef(i, 18'sh1FFFF, 1'b1);
      got_re.delete();
      got_im.delete();
      repeat (16) send(24'sh800000);
      repeat (15) send(24'sh7FFFFF);
      drain();
      chk("sat_count", got_re.size(), 31);
      chk("sat_re", got_re[$], -8388608);
      chk("sat_im", got_im[$], 8388607);

      // Backpressure
      rdy_mode = 0;
      tick(2);
      send(DW'($urandom));
      t = 0;
      while (!o_dout_valid && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      chk("bp_valid", o_dout_valid, 1);
      hold_re = o_dout_re;
      hold_im = o_dout_im;
      stable  = 1'b1;
      rdy_bad = 1'b0;
      repeat (20) begin
         @(negedge i_clk);
         if (o_dout_re !== hold_re || o_dout_im !== hold_im || !o_dout_valid) stable = 1'b0;
         if (o_din_ready) rdy_bad = 1'b1;
      end
      chk("bp_stable", stable, 1);
      chk("bp_din_ready_low", rdy_bad, 0);
      @(posedge i_clk);
      #1;
      rdy_mode = 1;
      @(posedge i_clk);
      #1;
      chk("bp_din_ready_after", o_din_ready, 1);
      chk("bp_valid_after", o_dout_valid, 0);

      // Continuous throughput
      acc_log.delete();
      i_din_valid = 1'b1;
      repeat (120) begin
         i_din = DW'($urandom);
         tick(1);
      end
      i_din_valid = 1'b0;
      drain();
      chk("tp_accepts", acc_log.size() >= 10, 1);
      for (int k = 1; k < acc_log.size(); k++)
         chk($sformatf("tp_spacing%0d", k), acc_log[k] - acc_log[k-1], 11);

      // Random coefficients, data, gaps and backpressure
      for (int i = 0; i < NC; i++) wcoef(i, CW'($urandom), 1'b1);
      rdy_mode = 2;
      for (int s = 0; s < 60; s++) begin
         tick($urandom_range(0, 3));
         x = DW'($urandom);
         if (s % 2 == 1) x = x >>> 12;
         send(x);
      end
      drain();
      rdy_mode = 1;
      tick(2);

      // Asynchronous reset in the middle of a MAC pass
      send(DW'($urandom));
      tick(2);
      #3;
      i_reset_n = 1'b0;
      #1;
      chk("rmac_din_ready", o_din_ready, 0);
      chk("rmac_dout_valid", o_dout_valid, 0);
      chk("rmac_dout_re", o_dout_re, 0);
      chk("rmac_dout_im", o_dout_im, 0);
      clear_model();
      for (int i = 0; i < NC; i++) mc[i] = '0;
      tick(2);
      i_reset_n = 1'b1;
      tick(2);
      chk("rmac_ready_2nd_edge", o_din_ready, 1);
      for (int s = 0; s < 17; s++) send(DW'($urandom));
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
